// File: rtl/decode_issue_pkg.sv
// Shared instruction encodings and field layout for the decode/issue stage and the ALU.
package decode_issue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned IMM_W  = 16;

  // Source-register positions inside the instruction word (inside imvalue)
  localparam int unsigned RN_LSB = 12;
  localparam int unsigned RM_LSB = 8;

  // Flag bit positions within {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ORR = 4'b0011;
  localparam logic [OPC_W-1:0] OP_EOR = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SHF = 4'b0101;
  localparam logic [OPC_W-1:0] OP_MOV = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MVN = 4'b0111;
  localparam logic [OPC_W-1:0] OP_CMP = 4'b1000;
  localparam logic [OPC_W-1:0] OP_CMN = 4'b1001;
  localparam logic [OPC_W-1:0] OP_TST = 4'b1010;
  localparam logic [OPC_W-1:0] OP_NOP = 4'b1111;

  localparam logic [COND_W-1:0] COND_AL   = 4'b0000;
  localparam logic [COND_W-1:0] COND_EQ   = 4'b0001;
  localparam logic [COND_W-1:0] COND_GT   = 4'b0010;
  localparam logic [COND_W-1:0] COND_LTNZ = 4'b0011;
  localparam logic [COND_W-1:0] COND_GE   = 4'b0100;
  localparam logic [COND_W-1:0] COND_LT   = 4'b0101;
  localparam logic [COND_W-1:0] COND_HI   = 4'b0110;
  localparam logic [COND_W-1:0] COND_CC   = 4'b0111;
  localparam logic [COND_W-1:0] COND_CS   = 4'b1000;

  localparam logic [SRC_W-1:0] SR_NONE = 3'd0;
  localparam logic [SRC_W-1:0] SR_LSL  = 3'd1;
  localparam logic [SRC_W-1:0] SR_LSR  = 3'd2;
  localparam logic [SRC_W-1:0] SR_ASR  = 3'd3;
  localparam logic [SRC_W-1:0] SR_ROR  = 3'd4;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [OPC_W-1:0]  opcode;
    logic              sbit;
    logic [SRC_W-1:0]  srcontrol;
    logic [RIDX_W-1:0] rd;
    logic [IMM_W-1:0]  imvalue;
  } instr_t;

  localparam instr_t NOP_INSTR = '{cond: COND_AL, opcode: OP_NOP, sbit: 1'b0,
                                   srcontrol: SR_NONE, rd: 4'h0, imvalue: 16'h0000};

  function automatic logic op_writes_rd(input logic [OPC_W-1:0] op);
    return ~op[OPC_W-1];
  endfunction

  function automatic logic op_illegal(input logic [OPC_W-1:0] op);
    return (op >= 4'b1011) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/decode_issue_cond.sv
// Condition-code evaluator: decides whether an instruction's cond passes against {N,Z,C,V}.
module cond_check
  import decode_issue_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              met
);

  logic n, z, c, v;

  always_comb begin
    n   = flags[FLAG_N];
    z   = flags[FLAG_Z];
    c   = flags[FLAG_C];
    v   = flags[FLAG_V];
    met = 1'b1;
    case (cond)
      COND_EQ:   met = z;
      COND_GT:   met = ~z & (n == v);
      COND_LTNZ: met = ~z & (n != v);
      COND_GE:   met = (n == v);
      COND_LT:   met = (n != v);
      COND_HI:   met = ~z & c;
      COND_CC:   met = ~c;
      COND_CS:   met = c;
      default:   met = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: register file, flags register, issue register with writeback bypass.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_instr,
  output logic              in_ready,
  input  logic              hold,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [COND_W-1:0] alu_cond,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [FLAG_W-1:0] alu_inflags,
  output logic              alu_sbit,
  output logic [SRC_W-1:0]  alu_srcontrol,
  output logic [IMM_W-1:0]  alu_imvalue,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [FLAG_W-1:0] alu_outflags,
  output logic              issue_valid,
  output logic              illegal
);

  instr_t            iss_q, iss_d, in_fields;
  logic              issue_valid_q, issue_valid_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic [RIDX_W-1:0] rn, rm;
  logic              advance, cond_met, wb_en, flags_we;

  assign in_fields = instr_t'(in_instr);
  assign rn        = in_instr[RN_LSB +: RIDX_W];
  assign rm        = in_instr[RM_LSB +: RIDX_W];
  assign advance   = ~hold;
  assign in_ready  = ~hold;

  cond_check u_cond_check (
    .cond  (iss_q.cond),
    .flags (flags_q),
    .met   (cond_met)
  );

  // Retirement of the issued instruction happens at the edge that ends its issue cycle
  assign wb_en    = issue_valid_q & advance & cond_met & op_writes_rd(iss_q.opcode);
  assign flags_we = issue_valid_q & advance & cond_met & ~op_illegal(iss_q.opcode)
                  & (iss_q.sbit | (iss_q.opcode == OP_CMP));

  always_comb begin
    iss_d         = iss_q;
    issue_valid_d = issue_valid_q;
    illegal_d     = 1'b0;
    in1_d         = in1_q;
    in2_d         = in2_q;
    flags_d       = flags_we ? alu_outflags : flags_q;
    if (advance) begin
      if (in_valid) begin
        iss_d         = in_fields;
        issue_valid_d = 1'b1;
        illegal_d     = op_illegal(in_fields.opcode);
        // Operands forward the result being written at this same edge
        in1_d         = (wb_en && (iss_q.rd == rn)) ? alu_result : rf_q[rn];
        in2_d         = (wb_en && (iss_q.rd == rm)) ? alu_result : rf_q[rm];
      end else begin
        iss_d         = NOP_INSTR;
        issue_valid_d = 1'b0;
        in1_d         = '0;
        in2_d         = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_q         <= NOP_INSTR;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      in1_q         <= '0;
      in2_q         <= '0;
      flags_q       <= '0;
    end else begin
      iss_q         <= iss_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      flags_q       <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[iss_q.rd] <= alu_result;
    end
  end

  assign alu_in1       = in1_q;
  assign alu_in2       = in2_q;
  assign alu_cond      = iss_q.cond;
  assign alu_opcode    = iss_q.opcode;
  assign alu_sbit      = iss_q.sbit;
  assign alu_srcontrol = iss_q.srcontrol;
  assign alu_imvalue   = iss_q.imvalue;
  assign alu_inflags   = flags_q;
  assign issue_valid   = issue_valid_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed vector bench for decode_issue; the bench plays the ALU by driving alu_result/alu_outflags.
module tb_decode_issue;

  logic        clk, reset, in_valid, hold, in_ready;
  logic [31:0] in_instr, alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_cond, alu_opcode, alu_inflags, alu_outflags;
  logic        alu_sbit, issue_valid, illegal;
  logic [2:0]  alu_srcontrol;
  logic [15:0] alu_imvalue;

  int n_cmp = 0;
  int n_bad = 0;

  decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .hold(hold), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cond(alu_cond),
    .alu_opcode(alu_opcode), .alu_inflags(alu_inflags), .alu_sbit(alu_sbit),
    .alu_srcontrol(alu_srcontrol), .alu_imvalue(alu_imvalue), .alu_result(alu_result),
    .alu_outflags(alu_outflags), .issue_valid(issue_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] res;
    logic [3:0]  oflags;
    logic        e_iv;
    logic [3:0]  e_op;
    logic [31:0] e_in1;
    logic [31:0] e_in2;
    logic [3:0]  e_fl;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins(input logic [3:0] c, input logic [3:0] op, input logic s,
                                      input logic [2:0] src, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [7:0] imm);
    return {c, op, s, src, rd, rn, rm, imm};
  endfunction

  function automatic vec_t mkv(input logic h, input logic v, input logic [31:0] i,
                               input logic [31:0] r, input logic [3:0] of, input logic eiv,
                               input logic [3:0] eop, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [3:0] efl, input logic eill);
    vec_t t;
    t.hold = h; t.valid = v; t.instr = i; t.res = r; t.oflags = of;
    t.e_iv = eiv; t.e_op = eop; t.e_in1 = e1; t.e_in2 = e2; t.e_fl = efl; t.e_ill = eill;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic [31:0] i,
                       input logic [31:0] r, input logic [3:0] of);
    hold = h; in_valid = v; in_instr = i; alu_result = r; alu_outflags = of;
  endtask

  logic [31:0] live;
  logic [31:0] junk;

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    live = 32'h0;
    junk = ins(4'h0, 4'h5, 1'b1, 3'd7, 4'h9, 4'h9, 4'h9, 8'hFF);

    //            hold valid instr                                        res            of    iv op    in1            in2            fl    ill
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h6, 0, 3'd3, 4'h1, 4'h0, 4'h0, 8'h05), 32'h0,   4'h0, 1, 4'h6, 32'h0,   32'h0,   4'h0, 0));
    vecs.push_back(mkv(0, 0, 32'h0,                                           32'h5,     4'hF, 0, 4'hF, 32'h0,   32'h0,   4'h0, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 0, 3'd0, 4'h2, 4'h1, 4'h1, 8'h00), 32'h0,   4'h0, 1, 4'h0, 32'h5,   32'h5,   4'h0, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h1, 0, 3'd1, 4'h4, 4'h2, 4'h1, 8'h10), 32'hA,   4'hF, 1, 4'h1, 32'hA,   32'h5,   4'h0, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h8, 0, 3'd5, 4'h5, 4'h2, 4'h4, 8'h00), 32'h77,  4'h0, 1, 4'h8, 32'hA,   32'h77,  4'h0, 0));
    vecs.push_back(mkv(0, 1, ins(4'h1, 4'h2, 0, 3'd0, 4'h6, 4'h5, 4'h0, 8'h00), 32'h99,  4'h4, 1, 4'h2, 32'h0,   32'h0,   4'h4, 0));
    vecs.push_back(mkv(0, 1, ins(4'h2, 4'h3, 0, 3'd0, 4'h7, 4'h6, 4'h0, 8'h00), 32'h33,  4'hF, 1, 4'h3, 32'h33,  32'h0,   4'h4, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h9, 0, 3'd0, 4'h0, 4'h7, 4'h6, 8'h00), 32'h44,  4'h0, 1, 4'h9, 32'h0,   32'h33,  4'h4, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'hC, 1, 3'd0, 4'h1, 4'h1, 4'h2, 8'h00), 32'h55,  4'h0, 1, 4'hC, 32'h5,   32'hA,   4'h4, 1));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 1, 3'd0, 4'h8, 4'h1, 4'h0, 8'h00), 32'hDEAD, 4'h3, 1, 4'h0, 32'h5,  32'h0,   4'h4, 0));
    vecs.push_back(mkv(0, 0, 32'h0,                                           32'h123,   4'h9, 0, 4'hF, 32'h0,   32'h0,   4'h9, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 1, 3'd2, 4'h0, 4'h8, 4'h1, 8'h00), 32'h0,   4'h0, 1, 4'h0, 32'h123, 32'h5,   4'h9, 0));
    // three stalled cycles with junk on the input and a tempting ALU result
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(1, 1, junk,                                          32'hBAD,   4'hF, 1, 4'h0, 32'h123, 32'h5,   4'h9, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 0, 3'd0, 4'h9, 4'h0, 4'h0, 8'h00), 32'h321, 4'h6, 1, 4'h0, 32'h321, 32'h321, 4'h6, 0));
    vecs.push_back(mkv(0, 0, 32'h0,                                           32'h10,    4'hF, 0, 4'hF, 32'h0,   32'h0,   4'h6, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'hA, 0, 3'd0, 4'h0, 4'h9, 4'h0, 8'h00), 32'h0,   4'h0, 1, 4'hA, 32'h10,  32'h321, 4'h6, 0));
    vecs.push_back(mkv(0, 1, ins(4'h7, 4'h0, 1, 3'd0, 4'hA, 4'h0, 4'h0, 8'h00), 32'hEE,  4'hF, 1, 4'h0, 32'h321, 32'h321, 4'h6, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 0, 3'd0, 4'hB, 4'hA, 4'h0, 8'h00), 32'h66,  4'hF, 1, 4'h0, 32'h0,   32'h321, 4'h6, 0));
    vecs.push_back(mkv(0, 0, 32'h0,                                           32'h77,    4'h0, 0, 4'hF, 32'h0,   32'h0,   4'h6, 0));
    vecs.push_back(mkv(0, 1, ins(4'h0, 4'h0, 0, 3'd0, 4'h0, 4'hB, 4'hA, 8'h00), 32'h0,   4'h0, 1, 4'h0, 32'h77,  32'h0,   4'h6, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst issue_valid", 32'(issue_valid), 32'h0);
    chk("rst illegal",     32'(illegal),     32'h0);
    chk("rst alu_opcode",  32'(alu_opcode),  32'hF);
    chk("rst alu_in1",     alu_in1,          32'h0);
    chk("rst alu_in2",     alu_in2,          32'h0);
    chk("rst alu_inflags", 32'(alu_inflags), 32'h0);
    chk("rst fields", {8'h0, alu_cond, alu_sbit, alu_srcontrol, alu_imvalue}, 32'h0);
    chk("rst in_ready",    32'(in_ready),    32'h1);
    @(negedge clk);
    reset = 1'b1;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].hold, vecs[i].valid, vecs[i].instr, vecs[i].res, vecs[i].oflags);
      if (!vecs[i].hold && vecs[i].valid) live = vecs[i].instr;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      chk($sformatf("row%0d alu_opcode", i),  32'(alu_opcode),  32'(vecs[i].e_op));
      chk($sformatf("row%0d alu_in1", i),     alu_in1,          vecs[i].e_in1);
      chk($sformatf("row%0d alu_in2", i),     alu_in2,          vecs[i].e_in2);
      chk($sformatf("row%0d alu_inflags", i), 32'(alu_inflags), 32'(vecs[i].e_fl));
      chk($sformatf("row%0d illegal", i),     32'(illegal),     32'(vecs[i].e_ill));
      chk($sformatf("row%0d in_ready", i),    32'(in_ready),    32'(!vecs[i].hold));
      if (vecs[i].e_iv)
        chk($sformatf("row%0d fields", i),
            32'({alu_cond, alu_sbit, alu_srcontrol, alu_imvalue}),
            32'({live[31:28], live[23:20], live[15:0]}));
    end

    // Reset asserted while ADD rd=3 is in its issue cycle
    drive(1'b0, 1'b1, ins(4'h0, 4'h0, 0, 3'd0, 4'h3, 4'h0, 4'h0, 8'h00), 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("mid opcode before reset", 32'(alu_opcode), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h5A5A, 4'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("mid issue_valid", 32'(issue_valid), 32'h0);
    chk("mid alu_opcode",  32'(alu_opcode),  32'hF);
    chk("mid alu_in1",     alu_in1,          32'h0);
    chk("mid alu_inflags", 32'(alu_inflags), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, ins(4'h0, 4'h6, 0, 3'd0, 4'h1, 4'h3, 4'h0, 8'h00), 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("post-reset accept", 32'(issue_valid), 32'h1);
    chk("post-reset R3",     alu_in1,          32'h0);
    chk("post-reset R0",     alu_in2,          32'h0);
    chk("post-reset flags",  32'(alu_inflags), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-003 in_valid  input  1  instruction word present on in_instr.
REQ-004 in_instr  input  32  instruction: [31:28] cond, [27:24] opcode, [23] sbit, [22:20] srcontrol, [19:16] rd, [15:0] imvalue (rn=[15:12], rm=[11:8]).
REQ-005 in_ready  output  1  block accepts in_instr this cycle; equals ~hold.
REQ-006 hold  input  1  downstream stall; freezes the issue register and writeback.
REQ-007 alu_in1, alu_in2  output  32 each  operands from rn, rm of the issued instruction.
REQ-008 alu_cond, alu_opcode, alu_inflags  output  4 each; alu_sbit output 1; alu_srcontrol output 3; alu_imvalue output 16: registered fields of the issued instruction and the current flags register {N,Z,C,V}.
REQ-009 alu_result  input  32  combinational ALU result for the issued instruction.
REQ-010 alu_outflags  input  4  combinational ALU flags {N,Z,C,V}.
REQ-011 issue_valid  output  1  issue register holds a live instruction.
REQ-012 illegal  output  1  one-cycle pulse when an opcode in 4'b1011..4'b1110 is issued.

Function
REQ-013 Accept: on a rising edge with in_valid=1 and hold=0, the block shall load in_instr fields into the issue register and set issue_valid=1; with in_valid=0 and hold=0, issue_valid shall clear to 0 and alu_opcode shall become 4'b1111.
REQ-014 Latency: operands and fields shall appear on alu_* outputs exactly one cycle after acceptance.
REQ-015 Register file: 16 x 32-bit registers; two combinational read ports (rn, rm) sampled at acceptance; one write port.
REQ-016 Condition: the block shall evaluate cond against the flags register with the ALU table: 0001 Z; 0010 !Z&(N==V); 0011 !Z&(N!=V); 0100 N==V; 0101 N!=V; 0110 !Z&C; 0111 !C; 1000 C; all others true.
REQ-017 Writeback: at the edge ending an issue cycle with issue_valid=1, hold=0 and cond met, opcodes 0000..0111 shall write alu_result to rd.
REQ-018 Opcodes 1000 (CMP), 1001, 1010 and 1111 shall not write rd; 1011..1110 shall not write and shall assert illegal for that cycle.
REQ-019 Flags: at the same edge, the flags register shall load alu_outflags when cond met and (sbit=1 or opcode=1000); otherwise it holds.
REQ-020 Bypass: when an accepted instruction reads a register written at that same edge, the operand latched shall be the new alu_result, not the stale file value; both ports bypass independently.
REQ-021 Flags bypass: alu_inflags shall reflect a flags update made at the preceding edge (no stale flags).
REQ-022 Hold: while hold=1, the issue register, register file and flags register shall not change and in_ready=0; in_instr is ignored.
REQ-023 Condition failure: the issue register holds the original opcode; writeback gating alone suppresses effects.
REQ-024 Register 0 is a general register (no hardwired zero).

Reset
REQ-025 On reset=0: issue_valid=0, illegal=0, flags register=4'b0000, alu_opcode=4'b1111, all other alu_* outputs=0, all 16 registers=0.
REQ-026 Reset asserted mid-issue shall discard the in-flight writeback; first acceptance occurs on the first rising edge after reset deasserts.

Structure
REQ-027 Opcode, cond and srcontrol encodings and instruction field positions shall reside in a shared package used by both this block and the ALU.
REQ-028 The condition evaluator shall be a sub-module named cond_check (inputs cond, flags; output met).

Verification
REQ-029 Reset then accept opcode 0110 rd=1 imvalue=16'h0005 (ALU returns 5) -> R1=5 after writeback, flags unchanged 0000.
REQ-030 Back-to-back: ADD rd=2 (result 32'h0000_000A) immediately followed by instruction with rn=2 -> alu_in1=32'h0000_000A next cycle (bypass).
REQ-031 CMP sbit=0, alu_outflags=4'b0100 -> flags=0100, no rd write; next instruction cond=0001 writes, cond=0010 does not.
REQ-032 hold=1 for 3 cycles mid-stream -> in_ready=0, alu_* outputs, registers and flags stable; resumes with no lost or duplicated instruction.
REQ-033 Issue opcode 1100 -> illegal=1 for one cycle, no register or flag change.
REQ-034 Assert reset during an issue cycle of ADD rd=3 -> R3=0, issue_valid=0, alu_opcode=1111 immediately.
